uaslr_rekey_ctrl: RTL
=====================

Name: uaslr_rekey_ctrl

Overview:
- Producer side of the uASLR_config interface: generates, installs and periodically refreshes the randomization word consumed by the uASLR address/instruction translation wrapper.
- Sits between the SoC control bus and the core. Owns a Galois LFSR offset source and a software config register.
- Runs a drain handshake with the core so a new offset is never swapped in while instruction or data transactions are outstanding.

Parameters:
- RNG_WIDTH, 32, width of uASLR_config_o and the LFSR
- LFSR_SEED, 32'hACE1_1234, reset value of the LFSR; a value of zero is illegal
- LFSR_TAPS, 32'h8020_0003, Galois feedback mask
- PERIOD_WIDTH, 24, width of the auto-rekey period counter
- DRAIN_TIMEOUT, 256, cycles allowed in DRAIN before the rekey is aborted

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_we_i  in  1  one-cycle write strobe for the config register
- cfg_wdata_i  in  32  [0]=enable, [1]=rekey_now (self-clearing), [31:8]=auto period (0 disables auto rekey)
- cfg_rdata_o  out  32  readback: [0]=enable, [2]=busy, [3]=timeout_err (sticky), [31:8]=period
- drain_req_o  out  1  asks the core to stop issuing instruction and data requests
- drain_ack_i  in  1  core reports no outstanding transactions while drain_req_o is held
- uASLR_config_o  out  RNG_WIDTH  [RNG_WIDTH-1:2]=offset, [1]=0, [0]=enable
- rekey_done_o  out  1  one-cycle pulse when a new offset is installed

Behaviour:
- Reset:
  - LFSR=LFSR_SEED; enable=0; period=0; counter=0; timeout_err=0.
  - uASLR_config_o=0; drain_req_o=0; rekey_done_o=0; state=IDLE.
- LFSR: steps once per cycle in all states, for continuous entropy. next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
- Config write:
  - enable and period are updated the cycle after cfg_we_i.
  - Clearing enable takes effect on uASLR_config_o[0] immediately (next cycle) and does not wait for drain. The offset field is retained.
  - Setting enable does not by itself install an offset; software must issue rekey_now.
- Trigger: a rekey is requested when cfg_we_i with wdata[1]=1, or when the period counter reaches period with period!=0.
  - The counter increments only in IDLE while enabled and clears on every trigger and on any config write.
  - A trigger arriving outside IDLE is dropped; the period counter is already cleared.
- FSM:
  - IDLE: on trigger go to DRAIN, busy=1.
  - DRAIN: drain_req_o=1; the timeout counter counts.
    - drain_ack_i=1 goes to SWAP.
    - Timeout counter == DRAIN_TIMEOUT-1 without ack: set timeout_err, drop drain_req_o, go to IDLE, offset unchanged.
    - If ack and timeout occur in the same cycle, ack wins.
  - SWAP (1 cycle): drain_req_o=1. uASLR_config_o[RNG_WIDTH-1:2] <= lfsr[RNG_WIDTH-1:2]; bit1=0; bit0=enable.
  - SETTLE (1 cycle): drain_req_o=1; rekey_done_o=1 pulse; next state IDLE, where drain_req_o=0.
- Latency: trigger to new config visible = 2 cycles + drain wait.
- Mid-operation behaviour:
  - A reset in any state returns everything to reset values the next edge.
  - An enable=0 write during DRAIN or SWAP: the FSM completes, but the installed word has bit0=0.
- timeout_err is cleared only by a cfg write with wdata[3]=1.

Optional Feature:
- Macro: UASLR_NONZERO_OFFSET_EN.
- With the macro defined: in SWAP, if lfsr[RNG_WIDTH-1:2]==0, the FSM stays in SWAP for another cycle, with the LFSR stepping, until the field is nonzero. An identity mapping is never installed.
- Without the macro: SWAP is always exactly 1 cycle, and a zero offset is installed as drawn.

Decomposition:
- Package uaslr_pkg:
  - state enum {IDLE, DRAIN, SWAP, SETTLE}
  - config bit-index constants (CFG_EN_BIT=0, CFG_REKEY_BIT=1, CFG_BUSY_BIT=2, CFG_ERR_BIT=3, CFG_PERIOD_LSB=8)
  - uASLR_config field constants (OFFSET_LSB=2)
- Sub-module uaslr_lfsr: parameterized Galois LFSR with seed/taps, outputs the current state.

Test Plan:
- Reset with LFSR_SEED=32'hACE1_1234 -> uASLR_config_o=0, drain_req_o=0, cfg_rdata_o=0.
- Write 32'h0000_0003 (enable+rekey_now), drain_ack_i tied 1 -> drain_req_o high for 3 cycles, rekey_done_o pulses at cycle 4. uASLR_config_o = {lfsr_at_swap[31:2],2'b01}, matching the reference-model LFSR.
- Write period=10 with enable -> rekeys every 10 idle cycles plus handshake. Three consecutive installs produce three distinct offsets.
- drain_ack_i held 0, DRAIN_TIMEOUT=256 -> drain_req_o drops after 256 cycles, timeout_err=1, uASLR_config_o unchanged. Write wdata[3]=1 -> err clears.
- rekey_now during DRAIN plus enable=0 write -> the single rekey completes and uASLR_config_o[0]=0. The extra trigger is ignored (exactly one rekey_done_o pulse).
- With UASLR_NONZERO_OFFSET_EN, force the LFSR state to {30'b0,2'b01} at SWAP -> SWAP extends one cycle and the installed offset is nonzero.

Source files
------------

// File: rtl/uaslr_pkg.sv
// Shared types and bit positions for the uASLR rekey controller: FSM states,
// software config register layout and uASLR_config word layout.
package uaslr_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      SWAP   = 2'd2,
      SETTLE = 2'd3
   } state_t;

   // Config register layout (write and readback share the enable/period positions)
   localparam int CFG_EN_BIT     = 0;
   localparam int CFG_REKEY_BIT  = 1;
   localparam int CFG_BUSY_BIT   = 2;
   localparam int CFG_ERR_BIT    = 3;
   localparam int CFG_PERIOD_LSB = 8;
   localparam int CFG_WIDTH      = 32;

   // uASLR_config word: offset lives above a reserved zero bit and the enable bit
   localparam int OFFSET_LSB = 2;

endpackage

// File: rtl/uaslr_rekey_ctrl_lfsr.sv
// Galois LFSR offset source; free-running once out of reset so the drawn
// offset depends on how long the system has been running.
module uaslr_lfsr
  import uaslr_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hACE1_1234),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/uaslr_rekey_ctrl.sv
// uASLR rekey controller: owns the config register and LFSR, and swaps a new
// offset into uASLR_config_o only after the core has drained.
// Optional build macro UASLR_NONZERO_OFFSET_EN: SWAP redraws until the offset is nonzero.
module uaslr_rekey_ctrl
  import uaslr_pkg::*;
#(
   parameter int                   RNG_WIDTH     = 32,
   parameter logic [RNG_WIDTH-1:0] LFSR_SEED     = RNG_WIDTH'(32'hACE1_1234),
   parameter logic [RNG_WIDTH-1:0] LFSR_TAPS     = RNG_WIDTH'(32'h8020_0003),
   parameter int                   PERIOD_WIDTH  = 24,
   parameter int                   DRAIN_TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we_i,
   input  logic [31:0]          cfg_wdata_i,
   output logic [31:0]          cfg_rdata_o,
   output logic                 drain_req_o,
   input  logic                 drain_ack_i,
   output logic [RNG_WIDTH-1:0] uASLR_config_o,
   output logic                 rekey_done_o,
   output state_t               dbg_state
);

   localparam int                TO_W    = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

   state_t                  state_q, state_d;
   logic [RNG_WIDTH-1:0]    lfsr;
   logic [RNG_WIDTH-1:0]    config_q;
   logic                    enable_q;
   logic [PERIOD_WIDTH-1:0] period_q;
   logic [PERIOD_WIDTH-1:0] cnt_q;
   logic [TO_W-1:0]         to_cnt_q;
   logic                    err_q;
   logic                    busy;
   logic                    rekey_req;
   logic                    period_hit;
   logic                    trigger;
   logic                    timeout;
   logic                    offset_ok;
   logic                    en_next;
   logic                    unused_bits;

   uaslr_lfsr #(
      .WIDTH (RNG_WIDTH),
      .SEED  (LFSR_SEED),
      .TAPS  (LFSR_TAPS)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lfsr)
   );

   assign rekey_req  = cfg_we_i & cfg_wdata_i[CFG_REKEY_BIT];
   assign period_hit = (period_q != '0) && (cnt_q == period_q);
   assign trigger    = rekey_req | period_hit;
   assign timeout    = (to_cnt_q == TO_LAST);
   // Enable as it will read after this edge, so a same-cycle disable write wins
   assign en_next    = cfg_we_i ? cfg_wdata_i[CFG_EN_BIT] : enable_q;

`ifdef UASLR_NONZERO_OFFSET_EN
   assign offset_ok = |lfsr[RNG_WIDTH-1:OFFSET_LSB];
`else
   assign offset_ok = 1'b1;
`endif

   // Drain handshake: drain_req_o rises on entry to DRAIN and stays high through
   // SETTLE; drain_ack_i is sampled only in DRAIN, and a high ack there means the
   // core has nothing outstanding and will issue nothing while drain_req_o holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (trigger) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_ack_i)  state_d = SWAP;
            else if (timeout) state_d = IDLE;
         end
         SWAP: begin
            if (offset_ok) state_d = SETTLE;
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      drain_req_o  = 1'b0;
      rekey_done_o = 1'b0;
      busy         = 1'b0;
      case (state_q)
         DRAIN, SWAP: begin
            drain_req_o = 1'b1;
            busy        = 1'b1;
         end
         SETTLE: begin
            drain_req_o  = 1'b1;
            rekey_done_o = 1'b1;
            busy         = 1'b1;
         end
         default: begin
            drain_req_o = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enable_q <= 1'b0;
         period_q <= '0;
         cnt_q    <= '0;
         to_cnt_q <= '0;
         err_q    <= 1'b0;
         config_q <= '0;
      end else begin
         if (cfg_we_i) begin
            enable_q <= cfg_wdata_i[CFG_EN_BIT];
            period_q <= cfg_wdata_i[CFG_PERIOD_LSB +: PERIOD_WIDTH];
         end

         // Triggers that land outside IDLE are dropped, but still restart the period
         if (cfg_we_i || trigger) begin
            cnt_q <= '0;
         end else if (state_q == IDLE && enable_q) begin
            cnt_q <= cnt_q + PERIOD_WIDTH'(1);
         end

         if (state_q == DRAIN) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end else begin
            to_cnt_q <= '0;
         end

         if (state_q == DRAIN && timeout && !drain_ack_i) begin
            err_q <= 1'b1;
         end else if (cfg_we_i && cfg_wdata_i[CFG_ERR_BIT]) begin
            err_q <= 1'b0;
         end

         if (state_q == SWAP && offset_ok) begin
            config_q <= {lfsr[RNG_WIDTH-1:OFFSET_LSB], 1'b0, en_next};
         end else if (cfg_we_i && !cfg_wdata_i[CFG_EN_BIT]) begin
            config_q[0] <= 1'b0;
         end
      end
   end

   always_comb begin
      cfg_rdata_o                                   = '0;
      cfg_rdata_o[CFG_EN_BIT]                       = enable_q;
      cfg_rdata_o[CFG_BUSY_BIT]                     = busy;
      cfg_rdata_o[CFG_ERR_BIT]                      = err_q;
      cfg_rdata_o[CFG_PERIOD_LSB +: PERIOD_WIDTH]   = period_q;
   end

   assign uASLR_config_o = config_q;
   assign dbg_state      = state_q;

   assign unused_bits = ^{cfg_wdata_i[CFG_PERIOD_LSB-1:CFG_ERR_BIT+1],
                          cfg_wdata_i[CFG_BUSY_BIT], lfsr[OFFSET_LSB-1:0]};

endmodule
